gmii_rx_framer: RTL and testbench

//  Receive framer directly downstream of the 1000BASE-X/SGMII PCS/PMA GMII receive interface.

---
 rtl/gmii_rx_framer_if.sv | 23 ++
 rtl/gmii_rx_framer.sv | 187 ++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_framer_if.sv
// GMII receive side plus the framed payload stream and frame counters.
// The master drives GMII receive data (PCS side); the slave is the framer.
interface gmii_rx_framer_if;
   logic [7:0]  rx_data;
   logic        rx_dv;
   logic        rx_er;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_last;
   logic [2:0]  m_status;
   logic [15:0] good_frames;
   logic [15:0] bad_frames;

   modport master (
      output rx_data, rx_dv, rx_er,
      input  m_data, m_valid, m_last, m_status, good_frames, bad_frames
   );

   modport slave (
      input  rx_data, rx_dv, rx_er,
      output m_data, m_valid, m_last, m_status, good_frames, bad_frames
   );
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: finds preamble/SFD, strips preamble, SFD and FCS,
// checks CRC-32, length and PHY errors, and pushes payload bytes out with a
// fixed 6-cycle latency. A 4-byte window plus a 1-byte hold keep the FCS
// from ever being emitted; the hold is flushed with m_last on the first
// rx_dv=0 sample. Good/bad frame counters wrap at 16 bits.
module gmii_rx_framer #(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input logic             clock,
   input logic             reset,
   gmii_rx_framer_if.slave bus
);

   typedef enum logic [1:0] {
      S_DROP     = 2'd0,
      S_IDLE     = 2'd1,
      S_PREAMBLE = 2'd2,
      S_PAYLOAD  = 2'd3
   } state_t;

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME);
   localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME);
   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;

   // Reflected CRC-32, one whole byte per call, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] din);
      logic [31:0] c;
      c = crc ^ {24'h0, din};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   // Byte count sticks at FFFF instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t            state_q, state_d;
   logic [31:0]       crc_q, crc_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              phy_err_q, phy_err_d;
   logic [3:0][7:0]   win_q, win_d;
   logic [3:0]        win_vld_q, win_vld_d;
   logic [7:0]        hold_q, hold_d;
   logic              hold_vld_q, hold_vld_d;
   logic [7:0]        m_data_q, m_data_d;
   logic              m_valid_q, m_valid_d;
   logic              m_last_q, m_last_d;
   logic [2:0]        m_status_q, m_status_d;
   logic [15:0]       good_q, good_d;
   logic [15:0]       bad_q, bad_d;
   logic [2:0]        frame_status;

   // State register; reset parks the FSM in DROP until the line goes idle.
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_DROP;
      else       state_q <= state_d;
   end

   // Next-state decode on the sampled rx_dv/rx_data.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_DROP:     if (!bus.rx_dv) state_d = S_IDLE;
         S_IDLE:     if (bus.rx_dv)  state_d = (bus.rx_data == PRE_BYTE) ? S_PREAMBLE : S_DROP;
         S_PREAMBLE: begin
            if (!bus.rx_dv)                   state_d = S_IDLE;
            else if (bus.rx_data == PRE_BYTE) state_d = S_PREAMBLE;
            else if (bus.rx_data == SFD_BYTE) state_d = S_PAYLOAD;
            else                              state_d = S_DROP;
         end
         S_PAYLOAD:  if (!bus.rx_dv) state_d = S_IDLE;
         default:    state_d = S_DROP;
      endcase
   end

   // End-of-frame verdict from everything accumulated through the last byte.
   always_comb begin
      frame_status = {crc_q != CRC_RESIDUE, (cnt_q < MIN_LEN) || (cnt_q > MAX_LEN), phy_err_q};
   end

   // Output and datapath decode: window shift, hold flush, CRC, counters.
   always_comb begin
      crc_d      = crc_q;
      cnt_d      = cnt_q;
      phy_err_d  = phy_err_q;
      win_d      = win_q;
      win_vld_d  = win_vld_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      m_data_d   = m_data_q;
      m_valid_d  = 1'b0;
      m_last_d   = 1'b0;
      m_status_d = 3'b000;
      good_d     = good_q;
      bad_d      = bad_q;
      case (state_q)
         S_PREAMBLE: begin
            if (bus.rx_dv && bus.rx_data == SFD_BYTE) begin
               crc_d      = 32'hFFFFFFFF;
               cnt_d      = 16'd0;
               phy_err_d  = 1'b0;
               win_vld_d  = 4'b0000;
               hold_vld_d = 1'b0;
            end
         end
         S_PAYLOAD: begin
            if (bus.rx_dv) begin
               crc_d      = crc32_byte(crc_q, bus.rx_data);
               cnt_d      = sat_inc16(cnt_q);
               if (bus.rx_er) phy_err_d = 1'b1;
               win_d      = {win_q[2:0], bus.rx_data};
               win_vld_d  = {win_vld_q[2:0], 1'b1};
               hold_d     = win_q[3];
               hold_vld_d = win_vld_q[3];
               if (hold_vld_q) begin
                  m_valid_d = 1'b1;
                  m_data_d  = hold_q;
               end
            end else begin
               // Frame ended: flush the hold as the last beat, or count a runt.
               if (hold_vld_q) begin
                  m_valid_d  = 1'b1;
                  m_last_d   = 1'b1;
                  m_data_d   = hold_q;
                  m_status_d = frame_status;
                  if (frame_status == 3'b000) good_d = good_q + 16'd1;
                  else                        bad_d  = bad_q + 16'd1;
               end else begin
                  bad_d = bad_q + 16'd1;
               end
               win_vld_d  = 4'b0000;
               hold_vld_d = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   // Control and output flops; reset discards any frame in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         crc_q      <= 32'hFFFFFFFF;
         win_vld_q  <= 4'b0000;
         hold_vld_q <= 1'b0;
         m_data_q   <= 8'h00;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_status_q <= 3'b000;
         good_q     <= 16'd0;
         bad_q      <= 16'd0;
      end else begin
         crc_q      <= crc_d;
         win_vld_q  <= win_vld_d;
         hold_vld_q <= hold_vld_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         m_status_q <= m_status_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
      end
   end

   // Data flops; always re-initialised at SFD so they need no reset.
   always_ff @(posedge clock) begin
      cnt_q     <= cnt_d;
      phy_err_q <= phy_err_d;
      win_q     <= win_d;
      hold_q    <= hold_d;
   end

   assign bus.m_data      = m_data_q;
   assign bus.m_valid     = m_valid_q;
   assign bus.m_last      = m_last_q;
   assign bus.m_status    = m_status_q;
   assign bus.good_frames = good_q;
   assign bus.bad_frames  = bad_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: directed frames plus randomized frames, with a
// frame-level reference model that predicts each payload beat (cycle, data,
// last, status, counters) from the wire bytes and CRC-32 definition.
module tb_gmii_rx_framer;

   typedef struct {
      int          cyc;
      logic [7:0]  data;
      logic        last;
      logic [2:0]  status;
      logic [15:0] good;
      logic [15:0] bad;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   beats_seen = 0;
   int   lasts_seen = 0;
   logic [15:0] exp_good = 16'd0;
   logic [15:0] exp_bad  = 16'd0;
   beat_t exp_q[$];

   gmii_rx_framer_if bus ();

   gmii_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every beat must match the next predicted beat exactly.
   always @(negedge clk) begin
      beat_t e;
      n_cmp++;
      if (!bus.m_valid && (bus.m_last || bus.m_status != 3'b000)) begin
         n_fail++;
         $display("FAIL unqualified cyc=%0d last=%b status=%b, required 0/000", cyc, bus.m_last, bus.m_status);
      end
      if (bus.m_valid) begin
         beats_seen++;
         if (bus.m_last) lasts_seen++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected cyc=%0d data=%h last=%b status=%b, required none", cyc, bus.m_data, bus.m_last, bus.m_status);
         end else begin
            e = exp_q.pop_front();
            if (cyc !== e.cyc || bus.m_data !== e.data || bus.m_last !== e.last || bus.m_status !== e.status) begin
               n_fail++;
               $display("FAIL beat cyc/data/last/status=%0d/%h/%b/%b, required %0d/%h/%b/%b",
                        cyc, bus.m_data, bus.m_last, bus.m_status, e.cyc, e.data, e.last, e.status);
            end
            if (e.last) begin
               n_cmp++;
               if (bus.good_frames !== e.good || bus.bad_frames !== e.bad) begin
                  n_fail++;
                  $display("FAIL counters_at_last good/bad=%0d/%0d, required %0d/%0d",
                           bus.good_frames, bus.bad_frames, e.good, e.bad);
               end
            end
         end
      end
   end

   // Standard Ethernet FCS value of the first n bytes.
   function automatic logic [31:0] ref_crc(input logic [7:0] b[$], input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c ^= {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic make_frame(input int n, output logic [7:0] q[$]);
      logic [31:0] c;
      logic [7:0]  t;
      q = {};
      for (int i = 0; i < n; i++) begin
         t = 8'($urandom_range(0, 255));
         q.push_back(t);
      end
      c = ref_crc(q, n);
      for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      @(posedge clk);
      #1;
      bus.rx_dv   = dv;
      bus.rx_er   = er;
      bus.rx_data = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
   endtask

   // Sends preamble, SFD and body (payload+FCS) followed by one idle cycle,
   // predicting the beats. rst_idx>=0 pulses reset while that body byte is on the wire.
   task automatic send_frame(input int pre_n, input logic [7:0] body[$], input int er_idx, input int rst_idx);
      int          len;
      logic [2:0]  st;
      logic [31:0] fcs;
      len = body.size();
      st  = 3'b000;
      if (len >= 5) begin
         fcs   = {body[len-1], body[len-2], body[len-3], body[len-4]};
         st[2] = (ref_crc(body, len - 4) != fcs);
         st[1] = (len < 64) || (len > 1518);
         st[0] = (er_idx >= 0) && (er_idx < len);
      end
      for (int i = 0; i < pre_n; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int j = 0; j < len; j++) begin
         beat_t b;
         drive(1'b1, j == er_idx, body[j]);
         rst = (j == rst_idx);
         if (j < len - 4 && (rst_idx < 0 || j + 6 <= rst_idx)) begin
            b.cyc    = cyc + 6;
            b.data   = body[j];
            b.last   = 1'b0;
            b.status = 3'b000;
            if (j == len - 5) begin
               if (st == 3'b000) exp_good++;
               else              exp_bad++;
               b.last   = 1'b1;
               b.status = st;
            end
            b.good = exp_good;
            b.bad  = exp_bad;
            exp_q.push_back(b);
         end
      end
      if (rst_idx >= 0) begin
         exp_good = 16'd0;
         exp_bad  = 16'd0;
      end else if (len < 5) begin
         exp_bad++;
      end
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rx_data = 8'h00;
      rst = 1'b1;
      idle(3);
      n_cmp++;
      if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_status !== 3'b000 || bus.m_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs valid/last/status/data=%b/%b/%b/%h, required 0/0/000/00",
                  bus.m_valid, bus.m_last, bus.m_status, bus.m_data);
      end
      n_cmp++;
      if (bus.good_frames !== 16'd0 || bus.bad_frames !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_counters good/bad=%0d/%0d, required 0/0", bus.good_frames, bus.bad_frames);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_good_frame;
      logic [7:0] body[$];
      int b0;
      b0 = beats_seen;
      make_frame(60, body);
      send_frame(7, body, -1, -1);
      idle(10);
      n_cmp++;
      if (beats_seen - b0 !== 60 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL good_frame_beats got=%0d pending=%0d, required 60/0", beats_seen - b0, exp_q.size());
      end
      n_cmp++;
      if (bus.good_frames !== 16'd1 || bus.bad_frames !== 16'd0) begin
         n_fail++;
         $display("FAIL good_frame_counters good/bad=%0d/%0d, required 1/0", bus.good_frames, bus.bad_frames);
      end
   endtask

   task automatic test_crc_error;
      logic [7:0] body[$];
      make_frame(60, body);
      body[19][0] = ~body[19][0];
      send_frame(7, body, -1, -1);
      idle(10);
      n_cmp++;
      if (bus.bad_frames !== exp_bad || bus.good_frames !== exp_good || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL crc_error good/bad=%0d/%0d pending=%0d, required %0d/%0d/0",
                  bus.good_frames, bus.bad_frames, exp_q.size(), exp_good, exp_bad);
      end
   endtask

   task automatic test_phy_error;
      logic [7:0] body[$];
      make_frame(60, body);
      send_frame(7, body, 9, -1);
      idle(10);
      n_cmp++;
      if (bus.bad_frames !== exp_bad || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL phy_error bad=%0d pending=%0d, required %0d/0", bus.bad_frames, exp_q.size(), exp_bad);
      end
   endtask

   task automatic test_length;
      logic [7:0] body[$];
      int b0;
      b0 = beats_seen;
      body = '{8'h11, 8'h22, 8'h33};
      send_frame(7, body, -1, -1);
      idle(10);
      n_cmp++;
      if (beats_seen !== b0 || bus.bad_frames !== exp_bad) begin
         n_fail++;
         $display("FAIL runt beats=%0d bad=%0d, required 0/%0d", beats_seen - b0, bus.bad_frames, exp_bad);
      end
      b0 = beats_seen;
      make_frame(36, body);
      send_frame(7, body, -1, -1);
      idle(10);
      n_cmp++;
      if (beats_seen - b0 !== 36 || bus.bad_frames !== exp_bad || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL short_frame beats=%0d bad=%0d, required 36/%0d", beats_seen - b0, bus.bad_frames, exp_bad);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] b1[$];
      logic [7:0] b2[$];
      int b0, l0;
      logic [15:0] g0, bd0;
      b0 = beats_seen; l0 = lasts_seen; g0 = bus.good_frames; bd0 = bus.bad_frames;
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h12);
      idle(3);
      n_cmp++;
      if (beats_seen !== b0 || bus.good_frames !== g0 || bus.bad_frames !== bd0) begin
         n_fail++;
         $display("FAIL bad_preamble beats=%0d good/bad=%0d/%0d, required 0/%0d/%0d",
                  beats_seen - b0, bus.good_frames, bus.bad_frames, g0, bd0);
      end
      make_frame(60, b1);
      make_frame(60, b2);
      send_frame(7, b1, -1, -1);
      send_frame(7, b2, -1, -1);
      idle(10);
      n_cmp++;
      if (beats_seen - b0 !== 120 || lasts_seen - l0 !== 2 || bus.good_frames !== g0 + 16'd2) begin
         n_fail++;
         $display("FAIL back_to_back beats=%0d lasts=%0d good=%0d, required 120/2/%0d",
                  beats_seen - b0, lasts_seen - l0, bus.good_frames, g0 + 16'd2);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] body[$];
      make_frame(60, body);
      send_frame(7, body, -1, 29);
      idle(10);
      n_cmp++;
      if (bus.good_frames !== 16'd0 || bus.bad_frames !== 16'd0 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_frame good/bad=%0d/%0d pending=%0d, required 0/0/0",
                  bus.good_frames, bus.bad_frames, exp_q.size());
      end
      make_frame(60, body);
      send_frame(7, body, -1, -1);
      idle(10);
      n_cmp++;
      if (bus.good_frames !== 16'd1 || bus.bad_frames !== 16'd0) begin
         n_fail++;
         $display("FAIL after_reset_frame good/bad=%0d/%0d, required 1/0", bus.good_frames, bus.bad_frames);
      end
   endtask

   task automatic test_random;
      logic [7:0] body[$];
      int n, er, idx;
      for (int f = 0; f < 16; f++) begin
         if ($urandom_range(0, 2) == 0) n = $urandom_range(0, 3);
         else if ($urandom_range(0, 1) == 0) n = $urandom_range(1, 59);
         else n = $urandom_range(60, 180);
         make_frame(n, body);
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, body.size() - 1);
            body[idx][$urandom_range(0, 7)] ^= 1'b1;
         end
         er = ($urandom_range(0, 4) == 0) ? $urandom_range(0, body.size() - 1) : -1;
         send_frame($urandom_range(1, 7), body, er, -1);
         idle($urandom_range(0, 2));
      end
      idle(10);
      n_cmp++;
      if (bus.good_frames !== exp_good || bus.bad_frames !== exp_bad || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL random_counters good/bad=%0d/%0d pending=%0d, required %0d/%0d/0",
                  bus.good_frames, bus.bad_frames, exp_q.size(), exp_good, exp_bad);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_crc_error();
      test_phy_error();
      test_length();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
